ir_counter_bank: RTL
====================

# ir_counter_bank

Multi-channel, parametrised IR event counter for the sensor board. It synchronises and debounces `CHANNELS` IR detector lines and counts accepted detections per channel with saturation. It raises a sticky per-channel threshold flag and presents one selected channel's count for the display path. It sits beside the DHT11 front-end under the board top and supersedes the single-channel counter.

## Interface
- `CHANNELS`, 4: number of independent IR inputs (1..16).
- `CNT_W`, 8: width of each channel counter.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz). Minimum 2.
- `THRESH`, 10: count at or above which `thresh_hit` is set. Must be ≤ 2^CNT_W−1.
- `ACTIVE_LOW`, 1: 1 means the IR line is low while an object is detected.

Ports:
- `clk`  in  1  system clock, 50 MHz. One clock domain; every register uses the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IR`  in  CHANNELS  raw, asynchronous detector lines.
- `clear`  in  CHANNELS  per-channel synchronous clear of the count and `thresh_hit`.
- `sel`  in  max(1,$clog2(CHANNELS))  selects the channel shown on `count_out`.
- `count_out`  out  CNT_W  registered count of channel `sel`.
- `event_pulse`  out  CHANNELS  one-cycle strobe per accepted detection.
- `thresh_hit`  out  CHANNELS  sticky flag, 1 while count ≥ THRESH.
- `Salida_contador`  out  1  registered OR of all `thresh_hit` bits.

## Operation
- Synchroniser, per channel:
  - Two flip-flops, `s1` then `s2`.
  - Both reset to the inactive level: 1 when ACTIVE_LOW=1, otherwise 0.
- Debouncer, per channel:
  - Holds a stable level `stb` (reset = inactive) and a counter `dcnt`, width $clog2(DEBOUNCE_CYCLES), reset 0.
  - If `s2 == stb`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `stb <= s2` and `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - Any bounce back to `stb` restarts the qualification.
- Accepted detection: `stb` flips from inactive to active. Release edges are never counted.
- Counter, per channel:
  - On an accepted detection, `cnt <= cnt+1` and `event_pulse` = 1 for that cycle.
  - At 2^CNT_W−1 the count holds (saturates) and does not wrap. `event_pulse` still fires.
- `thresh_hit` is set in the same cycle the count reaches ≥ THRESH, and stays set until `clear` or `rst`.
- `clear[i]`:
  - Sets `cnt[i]` and `thresh_hit[i]` to 0.
  - Leaves the debouncer untouched.
  - If `clear[i]` and an accepted detection occur in the same cycle, `clear` wins: the count becomes 0 and the event is lost, but `event_pulse[i]` still fires.
- `sel` ≥ CHANNELS: `count_out` = 0.
- Reset values: `count_out` = 0, `event_pulse` = 0, `thresh_hit` = 0, `Salida_contador` = 0, all `cnt` = 0, all `dcnt` = 0, `stb` and `s1`/`s2` at the inactive level.

## Timing
- Let edge 0 be the first rising edge that samples a new, held `IR[i]` level.
  - `s2` shows the new level after edge 1.
  - `stb`, `cnt`, `event_pulse` and `thresh_hit` update at edge 1+DEBOUNCE_CYCLES.
- `count_out` follows `cnt[sel]` one edge later, at edge 2+DEBOUNCE_CYCLES. A change of `sel` is reflected after one edge.
- `Salida_contador` lags `thresh_hit` by one edge.
- A pulse held for fewer than DEBOUNCE_CYCLES+1 edges (as sampled at `s2`) is never accepted.
- Back-to-back detections need at least DEBOUNCE_CYCLES stable cycles of release between them.
- `rst` asserted mid-debounce discards the partial qualification. The first edge after `rst` deasserts behaves as edge 0 of a fresh input.
- Channels are fully independent; simultaneous events on several channels are all counted in the same cycle.

## Test plan
Unless stated, all scenarios use DEBOUNCE_CYCLES=4, CHANNELS=4, CNT_W=3, THRESH=3, ACTIVE_LOW=1, `sel`=0.
- Reset and clean press:
  - After reset, all outputs are 0.
  - Drive `IR[0]`=0 for 10 cycles → `event_pulse[0]` high exactly at edge 5, `cnt[0]`=1, `count_out`=1 at edge 6.
- Glitch rejection:
  - A 3-cycle low pulse on `IR[1]` → no `event_pulse`, `cnt[1]` stays 0.
  - A 4-cycle low pulse followed by 3 high cycles then 4 low cycles → exactly 1 count.
- Saturation and threshold:
  - 9 clean presses on `IR[2]` → `thresh_hit[2]` rises on the 3rd event, `Salida_contador` follows one edge later.
  - The count holds at 7 from the 7th press; the 8th and 9th still pulse `event_pulse[2]`.
- Clear priority: `clear[3]`=1 in the same cycle as an accepted detection with `cnt[3]`=2 → `cnt[3]`=0, `thresh_hit[3]`=0, `event_pulse[3]`=1.
- Simultaneous channels: all four inputs pressed together → all `event_pulse` bits high in the same cycle. Stepping `sel` 0..3 reads 1 on each channel.
- Reset mid-debounce: assert `rst` 2 cycles into a press, release it, keep `IR[0]` low → the event fires at edge 5 counted from the first post-reset edge, and the count is 1.

Source files
------------

// File: rtl/ir_counter_bank_if.sv
// Signal bundle between the IR counter bank and its driver: detector lines,
// per-channel clears, display select and the counter results.
interface ir_counter_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] IR;
    logic [CHANNELS-1:0] clear;
    logic [SEL_W-1:0]    sel;
    logic [CNT_W-1:0]    count_out;
    logic [CHANNELS-1:0] event_pulse;
    logic [CHANNELS-1:0] thresh_hit;
    logic                Salida_contador;

    modport master (
        output IR, clear, sel,
        input  count_out, event_pulse, thresh_hit, Salida_contador
    );

    modport slave (
        input  IR, clear, sel,
        output count_out, event_pulse, thresh_hit, Salida_contador
    );
endinterface

// File: rtl/ir_counter_bank.sv
// Multi-channel IR event counter: per-channel 2-flop synchroniser, debouncer,
// saturating counter with sticky threshold flag, and a selected-channel readout.
module ir_counter_bank #(
    parameter int CHANNELS        = 4,
    parameter int CNT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int THRESH          = 10,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    ir_counter_bank_if.slave    bus
);
    localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic              INACTIVE = ACTIVE_LOW;
    localparam logic              ACTIVE   = ~ACTIVE_LOW;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  THRESH_V = CNT_W'(THRESH);

    logic [CHANNELS-1:0] s1_q;
    logic [CHANNELS-1:0] s2_q;
    logic [CHANNELS-1:0] stb_q;
    logic [CHANNELS-1:0] stb_d;
    logic [DCNT_W-1:0]   dcnt_q [CHANNELS];
    logic [DCNT_W-1:0]   dcnt_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] event_q;
    logic [CHANNELS-1:0] event_d;
    logic [CHANNELS-1:0] thresh_q;
    logic [CHANNELS-1:0] thresh_d;
    logic [CNT_W-1:0]    count_out_q;
    logic [CNT_W-1:0]    count_out_d;
    logic                salida_q;
    logic                salida_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            stb_d[i]    = stb_q[i];
            dcnt_d[i]   = dcnt_q[i];
            event_d[i]  = 1'b0;
            cnt_d[i]    = cnt_q[i];
            thresh_d[i] = thresh_q[i];

            if (s2_q[i] == stb_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DCNT_MAX) begin
                stb_d[i]   = s2_q[i];
                dcnt_d[i]  = '0;
                // Only the press edge counts; releases just re-arm the channel.
                event_d[i] = (s2_q[i] == ACTIVE);
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end

            // Clear beats a coincident detection, but the strobe still fires.
            if (bus.clear[i]) begin
                cnt_d[i]    = '0;
                thresh_d[i] = 1'b0;
            end else begin
                if (event_d[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                thresh_d[i] = thresh_q[i] | (cnt_d[i] >= THRESH_V);
            end
        end
    end

    always_comb begin
        count_out_d = '0;
        if (int'(bus.sel) < CHANNELS) begin
            count_out_d = cnt_q[bus.sel];
        end
        salida_d = |thresh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= {CHANNELS{INACTIVE}};
            s2_q        <= {CHANNELS{INACTIVE}};
            stb_q       <= {CHANNELS{INACTIVE}};
            event_q     <= '0;
            thresh_q    <= '0;
            count_out_q <= '0;
            salida_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                dcnt_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            s1_q        <= bus.IR;
            s2_q        <= s1_q;
            stb_q       <= stb_d;
            event_q     <= event_d;
            thresh_q    <= thresh_d;
            count_out_q <= count_out_d;
            salida_q    <= salida_d;
            for (int i = 0; i < CHANNELS; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign bus.count_out       = count_out_q;
    assign bus.event_pulse     = event_q;
    assign bus.thresh_hit      = thresh_q;
    assign bus.Salida_contador = salida_q;
endmodule
